// File: rtl/osc_voice_sequencer.sv
// Shares one synchronous-read sine table across NUM_VOICES phase accumulators.
// Each sample_tick produces one summed sample, strobed on mix_valid.
module osc_voice_sequencer #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 32,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    localparam int VIDX_W    = $clog2(NUM_VOICES),
    localparam int MIX_W     = DATA_W + VIDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  cfg_we,
    input  logic [VIDX_W-1:0]     cfg_voice,
    input  logic [PHASE_W-1:0]    cfg_fcw,
    input  logic [NUM_VOICES-1:0] voice_mute,
    output logic                  rom_en,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic [MIX_W-1:0]      mix_out,
    output logic                  mix_valid,
    output logic                  busy,
    output logic                  overrun
);

    // state | meaning
    // IDLE  | waiting for sample_tick
    // RUN   | issuing one table read per voice, advancing its phase
    // DRAIN | last read in flight in the table
    // DONE  | last sample captured, mix_out updated
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(NUM_VOICES - 1);

    state_t state, state_nxt;

    logic [PHASE_W-1:0] phase [NUM_VOICES];
    logic [PHASE_W-1:0] fcw   [NUM_VOICES];
    logic [VIDX_W-1:0]  vidx;
    logic [VIDX_W-1:0]  rom_voice;
    logic [VIDX_W-1:0]  cap_voice;
    logic               cap_valid;
    logic [MIX_W-1:0]   acc;
    logic [MIX_W-1:0]   term;
    logic [MIX_W-1:0]   acc_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            S_IDLE:  if (sample_tick) state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (vidx == LAST_VOICE) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Muting applies at capture time; the voice's phase still advances.
    always_comb begin
        term = '0;
        if (!voice_mute[cap_voice]) term = {{VIDX_W{rom_data[DATA_W-1]}}, rom_data};
        acc_sum = acc + term;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                fcw[i]   <= '0;
            end
            vidx      <= '0;
            rom_voice <= '0;
            cap_voice <= '0;
            cap_valid <= 1'b0;
            acc       <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rom_en    <= 1'b0;
            mix_valid <= 1'b0;
            cap_valid <= rom_en;
            cap_voice <= rom_voice;

            if (cfg_we) fcw[cfg_voice] <= cfg_fcw;

            if (state == S_IDLE && sample_tick) begin
                acc  <= '0;
                vidx <= '0;
            end

            // Address comes from the pre-update phase; a coincident cfg write
            // only takes effect on the next frame because fcw is read here.
            if (state == S_RUN) begin
                rom_en      <= 1'b1;
                rom_addr    <= phase[vidx][PHASE_W-1 -: ADDR_W];
                rom_voice   <= vidx;
                phase[vidx] <= phase[vidx] + fcw[vidx];
                vidx        <= vidx + VIDX_W'(1);
            end

            if (cap_valid) acc <= acc_sum;

            if (state == S_DONE) begin
                mix_out   <= acc_sum;
                mix_valid <= 1'b1;
            end

            if (sample_tick && state != S_IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_osc_voice_sequencer.sv
// Bench for osc_voice_sequencer: directed frames, scoreboard of expected mixes
// (value and arrival cycle) checked by an independent monitor.
module tb_osc_voice_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_voice = '0;
    logic [31:0] cfg_fcw = '0;
    logic [3:0]  voice_mute = '0;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [17:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    logic        use_const = 1'b0;
    logic [15:0] rom_const = '0;
    logic [15:0] rom_q = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [17:0] mix;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    osc_voice_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_fcw     (cfg_fcw),
        .voice_mute  (voice_mute),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read table model: address value itself, or a constant.
    always @(posedge clk) if (rom_en) rom_q <= use_const ? rom_const : {6'b0, rom_addr};
    assign rom_data = rom_q;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && mix_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_mix_valid: got mix_out %0h at cycle %0d expected no strobe", mix_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mix_out", 32'(mix_out), 32'(e.mix));
                check("mix_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic write_fcw(int v, logic [31:0] w);
        @(posedge clk);
        #1;
        cfg_we    = 1'b1;
        cfg_voice = 2'(v);
        cfg_fcw   = w;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic frame(logic [17:0] exp);
        @(posedge clk);
        #1 sample_tick = 1'b1;
        sb.push_back('{exp, cyc + 7});
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (7) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rom_en", 32'(rom_en), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_mix_out", 32'(mix_out), 0);
        check("rst_mix_valid", 32'(mix_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Latency and read sequence
        @(posedge clk);
        #1 sample_tick = 1'b1;
        sb.push_back('{18'h0, cyc + 7});
        @(posedge clk);
        #1 sample_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("lat_rom_en", 32'(rom_en), 1);
            check("lat_rom_addr", 32'(rom_addr), 0);
            check("lat_busy", 32'(busy), 1);
        end
        @(posedge clk);
        @(negedge clk);
        check("lat_rom_en_off", 32'(rom_en), 0);
        check("lat_busy_done", 32'(busy), 0);
        repeat (4) @(posedge clk);
        #1;

        // Phase stepping
        write_fcw(0, 32'h0040_0000);
        frame(18'd0);
        frame(18'd1);
        frame(18'd2);
        do_reset();
        write_fcw(0, 32'h0040_0000);
        write_fcw(1, 32'h8000_0000);
        frame(18'd0);
        frame(18'd513);
        frame(18'd2);

        // Extremes
        do_reset();
        use_const = 1'b1;
        rom_const = 16'h7FFF;
        frame(18'h1FFFC);
        rom_const = 16'h8000;
        frame(18'h20000);

        // Mute; voice 0 phase keeps advancing
        do_reset();
        write_fcw(0, 32'h0040_0000);
        rom_const  = 16'h0100;
        voice_mute = 4'b0101;
        frame(18'h200);
        use_const  = 1'b0;
        voice_mute = 4'b0000;
        frame(18'd1);

        // Overrun and config race on voice 2
        do_reset();
        write_fcw(2, 32'h0040_0000);
        @(posedge clk);
        #1 sample_tick = 1'b1;
        sb.push_back('{18'd0, cyc + 7});
        @(posedge clk);
        #1 sample_tick = 1'b0;
        @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        cfg_we      = 1'b1;
        cfg_voice   = 2'd2;
        cfg_fcw     = 32'h0080_0000;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("overrun_set", 32'(overrun), 1);
        frame(18'd1);
        frame(18'd3);
        check("overrun_sticky", 32'(overrun), 1);

        // Reset mid-frame
        @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_rom_addr", 32'(rom_addr), 5);
        check("pre_rst_mix_out", 32'(mix_out), 3);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_rom_en", 32'(rom_en), 0);
        check("mid_rst_rom_addr", 32'(rom_addr), 0);
        check("mid_rst_mix_out", 32'(mix_out), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_mix_out", 32'(mix_out), 0);
        check("post_rst_busy", 32'(busy), 0);
        frame(18'd0);

        check("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
